// File: rtl/lcd_hex_display.sv
// HD44780 4-bit driver: power-on init by instruction, then shows value
// as one hex digit at DDRAM 0 and rewrites it whenever value changes.
module lcd_hex_display #(
  parameter int T_POWERUP = 2_000_000,
  parameter int T_INIT1   = 500_000,
  parameter int T_INIT2   = 20_000,
  parameter int T_E_SETUP = 4,
  parameter int T_E_HIGH  = 25,
  parameter int T_NIBBLE  = 100,
  parameter int T_CMD     = 5_000,
  parameter int T_CLEAR   = 200_000,
  parameter int DLY_W     = 21
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] value,
  output logic       ready,
  output logic       done,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [3:0] lcd_d
);

  typedef enum logic [2:0] {
    PWR_WAIT, INIT_NIB, INIT_CMD, IDLE, WRITE, FINISH
  } state_t;

  typedef enum logic [1:0] {
    PH_SETUP, PH_HIGH, PH_HOLD, PH_WAIT
  } phase_t;

  localparam logic [DLY_W-1:0] D_PWR   = DLY_W'(T_POWERUP - 2);
  localparam logic [DLY_W-1:0] D_INIT1 = DLY_W'(T_INIT1 - 1);
  localparam logic [DLY_W-1:0] D_INIT2 = DLY_W'(T_INIT2 - 1);
  localparam logic [DLY_W-1:0] D_SETUP = DLY_W'(T_E_SETUP - 1);
  localparam logic [DLY_W-1:0] D_HIGH  = DLY_W'(T_E_HIGH - 1);
  localparam logic [DLY_W-1:0] D_NIB   = DLY_W'(T_NIBBLE - 1);
  localparam logic [DLY_W-1:0] D_CMD   = DLY_W'(T_CMD - 1);
  localparam logic [DLY_W-1:0] D_CLEAR = DLY_W'(T_CLEAR - 1);

  state_t           state, state_nx;
  phase_t           phase, phase_nx;
  logic [2:0]       idx, idx_nx;
  logic [DLY_W-1:0] dly, dly_nx;
  logic [3:0]       shown, shown_nx;
  logic             pend, pend_nx;
  logic             e_nx, rs_nx;
  logic [3:0]       d_nx;
  logic             byte_end, last_nib;
  logic [DLY_W-1:0] wait_dly;

  function automatic logic [7:0] hex_ascii(input logic [3:0] v);
    return (v < 4'd10) ? 8'h30 + {4'h0, v} : 8'h37 + {4'h0, v};
  endfunction

  // Init nibbles reuse the byte path with both halves equal.
  function automatic logic [4:0] nib_of(
    input state_t     s,
    input logic [2:0] i,
    input logic [3:0] v
  );
    logic [7:0] b;
    logic       rs;
    b  = 8'h00;
    rs = 1'b0;
    case (s)
      INIT_NIB: b = (i == 3'd3) ? 8'h22 : 8'h33;
      INIT_CMD: begin
        case (i[2:1])
          2'd0:    b = 8'h28;
          2'd1:    b = 8'h0C;
          2'd2:    b = 8'h01;
          default: b = 8'h06;
        endcase
      end
      WRITE: begin
        rs = i[1];
        b  = i[1] ? hex_ascii(v) : 8'h80;
      end
      default: ;
    endcase
    return {rs, i[0] ? b[3:0] : b[7:4]};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= PWR_WAIT;
      phase  <= PH_SETUP;
      idx    <= '0;
      dly    <= '0;
      shown  <= '0;
      pend   <= 1'b1;
      lcd_e  <= 1'b0;
      lcd_rs <= 1'b0;
      lcd_d  <= '0;
    end else begin
      state  <= state_nx;
      phase  <= phase_nx;
      idx    <= idx_nx;
      dly    <= dly_nx;
      shown  <= shown_nx;
      pend   <= pend_nx;
      lcd_e  <= e_nx;
      lcd_rs <= rs_nx;
      lcd_d  <= d_nx;
    end
  end

  always_comb begin
    state_nx = state;
    phase_nx = phase;
    idx_nx   = idx;
    dly_nx   = dly;
    shown_nx = shown;
    pend_nx  = pend;
    e_nx     = lcd_e;
    rs_nx    = lcd_rs;
    d_nx     = lcd_d;
    byte_end = (state == INIT_NIB) || idx[0];
    last_nib = (state == INIT_CMD) ? (idx == 3'd7) : (idx == 3'd3);
    wait_dly = D_CMD;
    unique case (1'b1)
      state == INIT_NIB && idx == 3'd0:    wait_dly = D_INIT1;
      state == INIT_NIB && idx inside {3'd1, 3'd2}:
        wait_dly = D_INIT2;
      state == INIT_CMD && idx[2:1] == 2'd2: wait_dly = D_CLEAR;
      default: ;
    endcase
    case (state)
      PWR_WAIT: begin
        if (phase != PH_WAIT) begin
          phase_nx = PH_WAIT;
          dly_nx   = D_PWR;
        end else if (dly == '0) begin
          state_nx = INIT_NIB;
          phase_nx = PH_SETUP;
          idx_nx   = '0;
          dly_nx   = D_SETUP;
        end else begin
          dly_nx = dly - DLY_W'(1);
        end
      end
      IDLE: begin
        if (pend || value != shown) begin
          shown_nx = value;
          pend_nx  = 1'b0;
          state_nx = WRITE;
          phase_nx = PH_SETUP;
          idx_nx   = '0;
          dly_nx   = D_SETUP;
        end
      end
      FINISH: state_nx = IDLE;
      default: begin
        if (dly != '0) begin
          dly_nx = dly - DLY_W'(1);
        end else begin
          unique case (phase)
            PH_SETUP: begin
              phase_nx = PH_HIGH;
              dly_nx   = D_HIGH;
              e_nx     = 1'b1;
            end
            PH_HIGH: begin
              phase_nx = PH_HOLD;
              dly_nx   = D_NIB;
              e_nx     = 1'b0;
            end
            PH_HOLD: begin
              if (byte_end) begin
                phase_nx = PH_WAIT;
                dly_nx   = wait_dly;
              end else begin
                idx_nx   = idx + 3'd1;
                phase_nx = PH_SETUP;
                dly_nx   = D_SETUP;
              end
            end
            PH_WAIT: begin
              phase_nx = PH_SETUP;
              dly_nx   = D_SETUP;
              idx_nx   = idx + 3'd1;
              if (last_nib) begin
                idx_nx = '0;
                case (state)
                  INIT_NIB: state_nx = INIT_CMD;
                  INIT_CMD: state_nx = IDLE;
                  default:  state_nx = FINISH;
                endcase
              end
            end
          endcase
        end
      end
    endcase
    // RS/D must be valid from the first setup cycle of every nibble.
    if (phase_nx == PH_SETUP &&
        state_nx inside {INIT_NIB, INIT_CMD, WRITE})
      {rs_nx, d_nx} = nib_of(state_nx, idx_nx, shown_nx);
  end

  assign ready  = (state == IDLE);
  assign done   = (state == FINISH);
  assign lcd_rw = 1'b0;

endmodule

// File: tb/tb_lcd_hex_display.sv
// Self-checking bench for lcd_hex_display: nibble-stream capture,
// strobe timing monitor, vector table and randomized model checks.
module tb_lcd_hex_display;

  localparam int T_POWERUP = 100;
  localparam int T_INIT1   = 40;
  localparam int T_INIT2   = 20;
  localparam int T_E_SETUP = 2;
  localparam int T_E_HIGH  = 3;
  localparam int T_NIBBLE  = 4;
  localparam int T_CMD     = 10;
  localparam int T_CLEAR   = 30;
  localparam int DLY_W     = 8;
  localparam int T_NIBALL  = T_E_SETUP + T_E_HIGH + T_NIBBLE;
  localparam int T_UPD     = 4 * T_NIBALL + 2 * T_CMD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] value = 4'h0;
  logic       ready, done, lcd_rs, lcd_rw, lcd_e;
  logic [3:0] lcd_d;

  always #5 clk = ~clk;

  lcd_hex_display #(
    .T_POWERUP(T_POWERUP), .T_INIT1(T_INIT1), .T_INIT2(T_INIT2),
    .T_E_SETUP(T_E_SETUP), .T_E_HIGH(T_E_HIGH), .T_NIBBLE(T_NIBBLE),
    .T_CMD(T_CMD), .T_CLEAR(T_CLEAR), .DLY_W(DLY_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .ready(ready),
    .done(done), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
    .lcd_d(lcd_d)
  );

  typedef struct {
    logic [3:0] val;
    logic [7:0] ascii;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_done = 0;
  logic [4:0] cap[$];
  logic [4:0] exp_q[$];
  int rise_q[$];
  string hexs = "0123456789ABCDEF";
  logic [3:0] model_shown;

  // Strobe monitor: one sample per cycle, away from the rising edge.
  logic       e_prev = 1'b0;
  logic [4:0] prev_rsd = 5'h0;
  int         e_rise = 0, last_fall = 0, last_chg = 0;
  bit         have_fall = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      e_prev    = 1'b0;
      have_fall = 1'b0;
      last_chg  = cyc;
      prev_rsd  = {lcd_rs, lcd_d};
    end else begin
      checks++;
      if (lcd_rw !== 1'b0) begin
        errors++;
        $display("FAIL rw_zero got %b expected 0 cyc %0d", lcd_rw, cyc);
      end
      checks++;
      if (done && ready) begin
        errors++;
        $display("FAIL done_ready_excl got 11 expected not both cyc %0d",
                 cyc);
      end
      if (done) begin
        done_cnt++;
        last_done = cyc;
      end
      if ({lcd_rs, lcd_d} != prev_rsd) begin
        checks++;
        if (lcd_e || (have_fall && cyc - last_fall < T_NIBBLE)) begin
          errors++;
          $display("FAIL rsd_hold got change %0d after fall expected >= %0d",
                   cyc - last_fall, T_NIBBLE);
        end
        last_chg = cyc;
      end
      if (lcd_e && !e_prev) begin
        checks++;
        if (cyc - last_chg < T_E_SETUP) begin
          errors++;
          $display("FAIL rsd_setup got %0d expected >= %0d",
                   cyc - last_chg, T_E_SETUP);
        end
        e_rise = cyc;
        cap.push_back({lcd_rs, lcd_d});
        rise_q.push_back(cyc);
      end
      if (!lcd_e && e_prev) begin
        checks++;
        if (cyc - e_rise != T_E_HIGH) begin
          errors++;
          $display("FAIL e_high_width got %0d expected %0d",
                   cyc - e_rise, T_E_HIGH);
        end
        last_fall = cyc;
        have_fall = 1'b1;
      end
      e_prev   = lcd_e;
      prev_rsd = {lcd_rs, lcd_d};
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check_eq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input int act,
                           input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic push_byte(input logic rs, input logic [7:0] b);
    exp_q.push_back({rs, b[7:4]});
    exp_q.push_back({rs, b[3:0]});
  endtask

  task automatic push_init();
    exp_q.push_back(5'h03);
    exp_q.push_back(5'h03);
    exp_q.push_back(5'h03);
    exp_q.push_back(5'h02);
    push_byte(1'b0, 8'h28);
    push_byte(1'b0, 8'h0C);
    push_byte(1'b0, 8'h01);
    push_byte(1'b0, 8'h06);
  endtask

  task automatic push_write(input logic [3:0] v);
    push_byte(1'b0, 8'h80);
    push_byte(1'b1, hexs[int'(v)]);
  endtask

  task automatic clear_all();
    cap.delete();
    rise_q.delete();
    exp_q.delete();
  endtask

  task automatic compare_stream(input string name);
    check_eq({name, "_len"}, cap.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < cap.size(); i++)
      check_eq($sformatf("%s[%0d]", name, i), cap[i], exp_q[i]);
    clear_all();
  endtask

  task automatic wait_done(input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      tick();
      n++;
    end
    check_eq("done_count", done_cnt, target);
  endtask

  task automatic wait_ready(output int rc);
    int n;
    n = 0;
    while (!ready && n < 2000) begin
      tick();
      n++;
    end
    check_eq("ready_high", ready, 1);
    rc = cyc;
  endtask

  task automatic power_up();
    int rel, n;
    clear_all();
    tick();
    rst_n = 1'b1;
    rel = cyc;
    n = 0;
    while (rise_q.size() == 0 && n < T_POWERUP + 50) begin
      tick();
      n++;
    end
    check_eq("first_e_seen", rise_q.size(), 1);
    if (rise_q.size() > 0) begin
      check_rng("first_e_rise", rise_q[0] - rel,
                T_POWERUP + T_E_SETUP - 1, T_POWERUP + T_E_SETUP + 1);
      check_eq("first_nibble", cap[0], 5'h03);
    end
  endtask

  initial begin
    #400_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[5];
    int d0, rc, s, n;
    logic [3:0] a, c, v;
    tbl[0] = '{4'h9, 8'h39};
    tbl[1] = '{4'hA, 8'h41};
    tbl[2] = '{4'hF, 8'h46};
    tbl[3] = '{4'h5, 8'h35};
    tbl[4] = '{4'h0, 8'h30};

    #1 rst_n = 1'b0;
    repeat (4) tick();
    check_eq("reset_outputs",
             {ready, done, lcd_rs, lcd_rw, lcd_e, lcd_d}, 0);

    d0 = done_cnt;
    power_up();
    push_init();
    push_write(4'h0);
    wait_done(d0 + 1, 3000);
    wait_ready(rc);
    check_eq("ready_after_done", rc - last_done, 1);
    check_eq("init_rises", rise_q.size() > 10, 1);
    if (rise_q.size() > 10)
      check_rng("clear_gap", rise_q[10] - rise_q[9], T_CLEAR, 1000);
    compare_stream("init");
    model_shown = 4'h0;

    foreach (tbl[i]) begin
      clear_all();
      d0 = done_cnt;
      tick();
      value = tbl[i].val;
      s = cyc;
      tick();
      check_eq("ready_fall", ready, 0);
      wait_done(d0 + 1, 500);
      check_eq("update_latency", last_done - (s + 1), T_UPD);
      wait_ready(rc);
      check_eq("ready_after_done", rc - last_done, 1);
      push_byte(1'b0, 8'h80);
      push_byte(1'b1, tbl[i].ascii);
      compare_stream($sformatf("vec%0d", i));
    end

    clear_all();
    d0 = done_cnt;
    tick();
    value = 4'h1;
    repeat (10) tick();
    value = 4'h2;
    repeat (20) tick();
    value = 4'h3;
    wait_done(d0 + 2, 1000);
    wait_ready(rc);
    repeat (100) tick();
    check_eq("collapse_done", done_cnt - d0, 2);
    push_write(4'h1);
    push_write(4'h3);
    compare_stream("collapse");
    model_shown = 4'h3;

    for (int it = 0; it < 12; it++) begin
      int nw;
      clear_all();
      d0 = done_cnt;
      nw = 0;
      tick();
      if ($urandom_range(0, 1) == 0) begin
        v = 4'($urandom_range(0, 15));
        value = v;
        if (v != model_shown) begin
          push_write(v);
          model_shown = v;
          nw = 1;
        end
      end else begin
        a = model_shown ^ 4'($urandom_range(1, 15));
        value = a;
        push_write(a);
        model_shown = a;
        nw = 1;
        n = $urandom_range(2, 15);
        repeat (n) tick();
        value = 4'($urandom_range(0, 15));
        n = $urandom_range(1, 15);
        repeat (n) tick();
        c = 4'($urandom_range(0, 15));
        value = c;
        if (c != a) begin
          push_write(c);
          model_shown = c;
          nw = 2;
        end
      end
      wait_done(d0 + nw, 1000);
      repeat (20) tick();
      wait_ready(rc);
      check_eq("rand_done", done_cnt - d0, nw);
      compare_stream($sformatf("rand%0d", it));
    end

    rst_n = 1'b0;
    repeat (3) tick();
    power_up();
    n = 0;
    while (!(cap.size() >= 6 && lcd_e) && n < 2000) begin
      tick();
      n++;
    end
    check_eq("midcmd_e_high", lcd_e, 1);
    #1 rst_n = 1'b0;
    #1 check_eq("async_reset_outputs",
                {ready, done, lcd_rs, lcd_rw, lcd_e, lcd_d}, 0);
    repeat (3) tick();
    d0 = done_cnt;
    power_up();
    push_init();
    push_write(model_shown);
    wait_done(d0 + 1, 3000);
    wait_ready(rc);
    compare_stream("restart");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_hex_display.md
# lcd_hex_display

Consumer end of the button counter's 4-bit count: drives an HD44780-compatible character LCD in 4-bit mode and shows the current `value` as one hex digit at DDRAM address 0. After reset it runs the HD44780 power-on initialisation by instruction. It then rewrites the digit whenever `value` differs from the digit last written. The block sits between the counter's `l` output and the LCD pins, clocked from the 100 MHz system clock.

## Interface
Parameters (all in `clk` cycles at 100 MHz; the bench overrides them with small values):
- `T_POWERUP`, 2_000_000: delay after reset release before the first nibble (20 ms).
- `T_INIT1`, 500_000: wait after the first 0x3 init nibble (5 ms).
- `T_INIT2`, 20_000: wait after the second and third 0x3 nibbles (200 µs).
- `T_E_SETUP`, 4: RS and D valid before E rises.
- `T_E_HIGH`, 25: E high width.
- `T_NIBBLE`, 100: E low with RS and D held, after E falls.
- `T_CMD`, 5_000: wait after every byte except clear, and after the 0x2 init nibble (50 µs).
- `T_CLEAR`, 200_000: wait after the clear command 0x01 (2 ms).
- `DLY_W`, 21: delay counter width. It must hold the largest delay parameter.

Ports:
- `clk`, in, 1: system clock, rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `value`, in, 4: digit to display. No synchronisation; it comes from the same clock domain.
- `ready`, out, 1: high while idle after initialisation completes.
- `done`, out, 1: one-cycle pulse when a digit update finishes, after its T_CMD wait.
- `lcd_rs`, out, 1: 0 = instruction, 1 = data.
- `lcd_rw`, out, 1: constant 0 (write only).
- `lcd_e`, out, 1: enable strobe.
- `lcd_d`, out, 4: data nibble for LCD D7..D4.

## Operation
- Reset state: all outputs 0, including `ready`, `done` and `lcd_e`. The FSM enters PWR_WAIT, the delay counter clears, and the "pending first write" flag sets.
- FSM states:
  - PWR_WAIT: waits T_POWERUP, then goes to INIT_NIB.
  - INIT_NIB: sends the single nibbles 0x3, 0x3, 0x3, 0x2 with RS=0. The waits after them are T_INIT1, T_INIT2, T_INIT2 and T_CMD. Then goes to INIT_CMD.
  - INIT_CMD: sends the bytes 0x28, 0x0C, 0x01, 0x06 with RS=0. The wait after 0x01 is T_CLEAR; the others use T_CMD. Then goes to IDLE.
  - IDLE: `ready` is 1. If the pending flag is set or `value` differs from `shown`, the block:
    - latches `value` into `shown`;
    - clears the pending flag;
    - drops `ready`;
    - goes to WRITE.
  - WRITE: sends byte 0x80 with RS=0, then the ASCII code of `shown` with RS=1. The ASCII code is 0x30+v for v in 0..9 and 0x37+v for v in 10..15. Then the block pulses `done` and returns to IDLE.
- Byte transfer: the high nibble is sent first, then the low nibble, with no extra gap between them. The post-byte wait starts after the low nibble's T_NIBBLE phase.
- Nibble transfer, strictly in this order:
  - T_E_SETUP cycles with E=0 and RS/D driven;
  - T_E_HIGH cycles with E=1;
  - T_NIBBLE cycles with E=0 and RS/D held.
- Outside a transfer, `lcd_d` and `lcd_rs` keep their last driven values and `lcd_e` stays 0.
- `value` changes during WRITE or init are not lost:
  - the byte in flight uses the latched `shown`;
  - IDLE compares again on entry, so the final `value` is always displayed.
- Several changes during one write collapse into a single follow-up write of the latest value.
- Asserting reset mid-transfer forces `lcd_e`=0 and all other outputs to 0 at once (asynchronously). The full init sequence restarts after release.

## Timing
- All sequencing uses one down-counter of DLY_W bits; there are no derived clocks and no prescaler.
- The first rising edge of `lcd_e` comes exactly T_POWERUP+T_E_SETUP cycles after reset release, ±1 cycle.
- `ready` rises in the first IDLE cycle. A change is detected in the cycle after `value` changes while in IDLE, and `ready` falls in the same cycle the value is latched.
- One digit update lasts 4·(T_E_SETUP+T_E_HIGH+T_NIBBLE)+2·T_CMD cycles from latch to the `done` pulse. `ready` returns to 1 in the cycle after `done`.
- `done` and `ready` are never high in the same cycle.
- E-high width is exactly T_E_HIGH cycles.
- RS and D are stable from T_E_SETUP cycles before each E rise until T_NIBBLE cycles after each E fall.

## Test plan
- Reset and power-up: hold `rst_n`=0 → all outputs 0. Release with T_POWERUP=100 → no E edge for 100 cycles. The first E pulse carries D=0x3, RS=0.
- Full init with `value`=0: the captured nibble stream (RS,D) must be:
  - init nibbles: 0/3, 0/3, 0/3, 0/2;
  - init bytes: 0/2 0/8, 0/0 0/C, 0/0 0/1, 0/0 0/6;
  - first write: 0/8 0/0, 1/3 1/0.
  
  One `done` pulse follows, then `ready`=1. The gap after 0/0 0/1 must be at least T_CLEAR.
- Update to 0xA from idle: set `value`=4'hA → nibbles 0/8 0/0, 1/4 1/1, then `done` pulses once and `ready` goes back to 1.
- Changes during a write: go 0→1 in IDLE, then set `value`=2 and then 3 during the write → the write of '1' (1/3 1/1) completes. Exactly one further write follows with '3' (1/3 1/3), and there are 2 `done` pulses in total.
- Reset mid-operation: drop `rst_n` while E=1 during INIT_CMD → `lcd_e`=0 without waiting for a clock edge. After release the stream restarts from the first 0x3 nibble following T_POWERUP.
- Strobe timing checker active throughout all scenarios → every E-high width equals T_E_HIGH. RS and D are unchanged within the setup and hold windows, and `lcd_rw` stays 0 in every cycle.
